// File: rtl/combi_pkg.sv
// Shared types and constants for the combined ARM/RISC-V pipeline.
// Holds the ISA-switch FSM state encoding and the mode encodings.
package combi_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2
    } mode_state_t;

    localparam logic MODE_ARM = 1'b1;
    localparam logic MODE_RV  = 1'b0;

endpackage

// File: rtl/combi_sat_cnt.sv
// Saturating up-counter with synchronous active-high reset.
// Ports: clk, reset, inc (count enable), cnt (current value, sticks at all-ones).
module combi_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/combi_isa_mode_ctrl.sv
// ISA mode controller: holds the committed ARM/RISC-V mode, and on a
// mismatching D instruction stalls F/D, drains E/M/W with bubbles, then commits.
// Ports: clk, reset (sync, active-high), InstrValidD, ArmDecD, FlushDIn,
//   HzStallD in; ArmMode, StallF, StallD, FlushE, Switching, SwitchCnt out.
// Optional feature macro COMBI_MODE_LOCK_EN adds ModeLock in / IllegalD out.
module combi_isa_mode_ctrl
    import combi_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter bit RESET_ARM    = 1'b0,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InstrValidD,
    input  logic             ArmDecD,
    input  logic             FlushDIn,
    input  logic             HzStallD,
`ifdef COMBI_MODE_LOCK_EN
    input  logic             ModeLock,
    output logic             IllegalD,
`endif
    output logic             ArmMode,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic             Switching,
    output logic [CNT_W-1:0] SwitchCnt
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic RST_MODE = RESET_ARM ? MODE_ARM : MODE_RV;

    mode_state_t state_q;
    mode_state_t state_d;
    logic [DW-1:0] cnt_q;
    logic tgt_q;
    logic arm_q;
    logic mismatch;
    logic mode_lock;
    logic req;
    logic busy;

`ifdef COMBI_MODE_LOCK_EN
    assign mode_lock = ModeLock;
    assign IllegalD  = InstrValidD & mismatch
                     & ~FlushDIn & ModeLock;
`else
    assign mode_lock = 1'b0;
`endif

    assign mismatch = (ArmDecD != arm_q);
    assign req = InstrValidD & mismatch & ~FlushDIn
               & ~HzStallD & ~mode_lock;

    // State register plus the datapath that rides along with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            tgt_q   <= RST_MODE;
            arm_q   <= RST_MODE;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                RUN: begin
                    if (req) begin
                        tgt_q <= ArmDecD;
                        cnt_q <= DW'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    cnt_q <= cnt_q - DW'(1);
                end
                COMMIT: begin
                    arm_q <= tgt_q;
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    // Next-state logic; inputs only matter while in RUN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (req) state_d = DRAIN;
            end
            DRAIN: begin
                if (cnt_q == DW'(1)) state_d = COMMIT;
            end
            COMMIT: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Outputs decoded purely from state.
    always_comb begin
        busy = 1'b0;
        unique case (state_q)
            RUN:     busy = 1'b0;
            DRAIN:   busy = 1'b1;
            COMMIT:  busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign StallF    = busy;
    assign StallD    = busy;
    assign FlushE    = busy;
    assign Switching = busy;
    assign ArmMode   = arm_q;

    combi_sat_cnt #(
        .W(CNT_W)
    ) u_sw_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (state_q == COMMIT),
        .cnt  (SwitchCnt)
    );

endmodule
